lsu_dmem: RTL
=============

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data memory depth in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra access cycles inserted before response (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port ready  output  1  one-cycle response pulse.
REQ-011 SHALL have port rdata  output  32  extended load result, valid while ready=1.
REQ-012 SHALL have port err  output  1  access fault, valid while ready=1.
REQ-013 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when WAIT_STATES=0.
REQ-015 SHALL accept a request on a rising edge with req=1 in IDLE and register we, funct3, addr and wdata.
REQ-016 SHALL remain in WAIT for exactly WAIT_STATES cycles, counted by a down-counter loaded at acceptance.
REQ-017 SHALL assert ready for exactly one cycle (RESP), WAIT_STATES+1 cycles after the acceptance edge.
REQ-018 SHALL ignore req while busy=1; there is no queue.
REQ-019 SHALL perform a load by reading word addr[log2(DEPTH)+1:2] and extracting the lane from addr[1:0] (byte) or addr[1] (half), sign-extended for b/h and zero-extended for bu/hu.
REQ-020 SHALL commit a store on the edge entering RESP, writing only the addressed byte lanes (sb 1, sh 2, sw 4) and leaving the other lanes unchanged.
REQ-021 SHALL wrap addresses beyond DEPTH words modulo DEPTH; no fault is raised.
REQ-022 SHALL hold rdata at its last value outside RESP; rdata SHALL be 0 for stores and faulted accesses.
REQ-023 SHALL fault (err=1, no write, rdata=0) on illegal funct3: load 011/110/111; store other than 000/001/010.
REQ-024 SHALL allow a back-to-back request to be accepted in the IDLE cycle immediately after RESP.

Reset
REQ-025 SHALL, while reset=1, force state IDLE, counter 0, ready=0, err=0, busy=0, rdata=0.
REQ-026 SHALL, on reset mid-access, abort the access; a pending store SHALL NOT be written.
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL support macro LSU_DMEM_MISALIGN_TRAP_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 faults per REQ-023.
REQ-029 SHALL, when LSU_DMEM_MISALIGN_TRAP_EN is undefined, force misaligned low address bits to 0 (half: addr[0]; word: addr[1:0]) and complete the access normally with err=0.

Structure
REQ-030 SHALL take funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum from shared package lsu_pkg.
REQ-031 SHALL place lane extraction, extension and store byte-enable/merge in combinational sub-module lsu_align.

Verification
REQ-032 SHALL cover: WAIT_STATES=0, sw 0xDEADBEEF @0x64, then lw @0x64 -> ready 1 cycle after each acceptance, rdata=0xDEADBEEF.
REQ-033 SHALL cover: sb 0x80 @0x65 over word 0x00000000, then lb @0x65 -> 0xFFFFFF80; lbu @0x65 -> 0x00000080; lw @0x64 -> 0x00008000.
REQ-034 SHALL cover: WAIT_STATES=3, lh @0x66 of word 0x8001_1234 -> ready exactly 4 cycles after acceptance, rdata=0xFFFF8001, busy high for 4 cycles.
REQ-035 SHALL cover: trap enabled, sw @0x62 -> err=1, word 0x60 unchanged; trap disabled, same access -> word 0x60 written, err=0.
REQ-036 SHALL cover: WAIT_STATES=3, sw @0x10, reset asserted in WAIT -> busy=0 immediately, word 0x10 unchanged, next request accepted normally.
REQ-037 SHALL cover: DEPTH=256, sw 0x55 @0x400 -> lw @0x000 returns 0x00000055 (wrap).

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the data-memory load/store unit.
//               RV32I funct3 size/sign codes for loads and stores and the
//               encoding of the access state machine.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load codes (funct3)
  localparam logic [2:0] c_lb  = 3'b000;
  localparam logic [2:0] c_lh  = 3'b001;
  localparam logic [2:0] c_lw  = 3'b010;
  localparam logic [2:0] c_lbu = 3'b100;
  localparam logic [2:0] c_lhu = 3'b101;

  // Store codes (funct3)
  localparam logic [2:0] c_sb  = 3'b000;
  localparam logic [2:0] c_sh  = 3'b001;
  localparam logic [2:0] c_sw  = 3'b010;

  // Access state machine encoding
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t c_st_idle = 2'd0;
  localparam lsu_state_t c_st_wait = 2'd1;
  localparam lsu_state_t c_st_resp = 2'd2;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               Loads : selects the byte/half lane from the memory word and
//                       sign- or zero-extends it.
//               Stores: builds byte enables and merges the right-aligned
//                       store data into the current memory word.
//               Also decodes access faults (illegal funct3, and misaligned
//               half/word accesses when LSU_DMEM_MISALIGN_TRAP_EN is
//               defined; otherwise misaligned low bits are forced to 0).
// Ports       : i_is_store   - 1 = store, 0 = load
//               i_funct3     - RV32I size/sign code
//               i_byte_off   - addr[1:0] of the access
//               i_mem_word   - current content of the addressed word
//               i_wdata      - right-aligned store data
//               o_fault      - access must not complete (err)
//               o_load_data  - extended load result (0 on fault)
//               o_store_word - merged word to write back on a store
// Config      : LSU_DMEM_MISALIGN_TRAP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic        o_fault,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic        w_illegal;
  logic [1:0]  w_off;
  logic [15:0] w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_rep;
`ifdef LSU_DMEM_MISALIGN_TRAP_EN
  logic        w_misaligned;
`endif

  always_comb begin
    // Stores only know sb/sh/sw; loads additionally know lbu/lhu.
    if (i_is_store) begin
      w_illegal = i_funct3[2] | (i_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
    end

`ifdef LSU_DMEM_MISALIGN_TRAP_EN
    w_misaligned = ((i_funct3[1:0] == 2'b01) & i_byte_off[0]) |
                   ((i_funct3[1:0] == 2'b10) & (i_byte_off != 2'b00));
    o_fault      = w_illegal | w_misaligned;
    w_off        = i_byte_off;
`else
    o_fault = w_illegal;
    case (i_funct3[1:0])
      2'b01:   w_off = {i_byte_off[1], 1'b0};
      2'b10:   w_off = 2'b00;
      default: w_off = i_byte_off;
    endcase
`endif

    // Lane starting at the (effective) byte offset.
    w_lane = 16'(i_mem_word >> {w_off, 3'b000});

    case (i_funct3[1:0])
      2'b00: begin
        o_load_data = i_funct3[2] ? {24'h0, w_lane[7:0]}
                                  : {{24{w_lane[7]}}, w_lane[7:0]};
        w_be        = 4'b0001 << w_off;
        w_rep       = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_load_data = i_funct3[2] ? {16'h0, w_lane}
                                  : {{16{w_lane[15]}}, w_lane};
        w_be        = 4'b0011 << w_off;
        w_rep       = {2{i_wdata[15:0]}};
      end
      default: begin
        o_load_data = i_mem_word;
        w_be        = 4'b1111;
        w_rep       = i_wdata;
      end
    endcase

    if (o_fault) begin
      o_load_data = 32'h0;
    end

    // Replicated data means each enabled lane already sees the right bytes.
    for (int i = 0; i < 4; i++) begin
      o_store_word[8*i +: 8] = w_be[i] ? w_rep[8*i +: 8] : i_mem_word[8*i +: 8];
    end
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem
// Description : Load/store unit with a private word-organised data memory.
//               One access at a time: IDLE -> (WAIT x WAIT_STATES) -> RESP.
//               ready pulses for one cycle in RESP with rdata/err.
// Parameters  : DEPTH       - memory depth in 32-bit words (power of two)
//               WAIT_STATES - extra cycles before the response (0..15)
// Ports       : clk, reset (async, active high)
//               req, we, funct3, addr, wdata - request (sampled in IDLE)
//               ready, rdata, err            - response
//               busy                         - high whenever not IDLE
// Config      : LSU_DMEM_MISALIGN_TRAP_EN (handled in lsu_align)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         c_aw = $clog2(DEPTH);
  localparam logic [3:0] c_ws = 4'(WAIT_STATES);

  lsu_state_t         r_state;
  lsu_state_t         w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [c_aw+1:0]    r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH];

  logic               w_idle;
  logic               w_accept;
  logic               w_we;
  logic [2:0]         w_funct3;
  logic [c_aw+1:0]    w_addr;
  logic [31:0]        w_wdata;
  logic [c_aw-1:0]    w_idx;
  logic               w_fault;
  logic [31:0]        w_load_data;
  logic [31:0]        w_store_word;
  logic               w_enter_resp;
  logic               w_commit;
  logic               w_unused;

  // Upper address bits wrap away (modulo DEPTH).
  assign w_unused = &{1'b0, addr[31:c_aw+2]};

  assign w_idle   = (r_state == c_st_idle);
  // A request seen during reset must not start (and with no wait states,
  // commit) an access.
  assign w_accept = w_idle & req & ~reset;

  // With no wait states the access completes on the acceptance edge itself,
  // so in IDLE the live request fields feed the datapath directly.
  assign w_we     = w_idle ? we                  : r_we;
  assign w_funct3 = w_idle ? funct3              : r_funct3;
  assign w_addr   = w_idle ? addr[c_aw+1:0]      : r_addr;
  assign w_wdata  = w_idle ? wdata               : r_wdata;
  assign w_idx    = w_addr[c_aw+1:2];

  lsu_align u_align (
    .i_funct3     (w_funct3),
    .i_is_store   (w_we),
    .i_byte_off   (w_addr[1:0]),
    .i_mem_word   (r_mem[w_idx]),
    .i_wdata      (w_wdata),
    .o_fault      (w_fault),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          if (c_ws == 4'd0) begin
            w_state_nxt = c_st_resp;
          end else begin
            w_state_nxt = c_st_wait;
            w_cnt_nxt   = c_ws;
          end
        end
      end
      c_st_wait: begin
        // Counter holds the WAIT cycles still to spend, including this one.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = c_st_resp;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      c_st_resp: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_enter_resp = (w_state_nxt == c_st_resp) && (r_state != c_st_resp);
  assign w_commit     = w_enter_resp & w_we & ~w_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we     <= we;
        r_funct3 <= funct3;
        r_addr   <= addr[c_aw+1:0];
        r_wdata  <= wdata;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_we | w_fault) ? 32'h0 : w_load_data;
        r_err   <= w_fault;
      end
    end
  end

  // Memory is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  assign ready = (r_state == c_st_resp);
  assign err   = r_err & ready;
  assign busy  = ~w_idle;
  assign rdata = r_rdata;

endmodule : lsu_dmem
`default_nettype wire
